// File: rtl/limbus_usec_scheduler.sv
// Microsecond tick consumer: owns the 1 us timer over Avalon-MM, keeps a 32-bit timestamp and alarms.
// Tick lands on the irq edge; timer writes hold under tmr_waitrequest; CPU slave has no wait states.
module limbus_usec_scheduler #(
    parameter int NUM_ALARMS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tmr_irq,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic        tmr_waitrequest,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    typedef enum logic [1:0] {INIT, IDLE, ACK, WAIT_LOW} state_t;

    state_t state, state_nxt;
    logic   tick;

    logic [31:0]           ts;
    logic [15:0]           ts_shadow;
    logic [NUM_ALARMS-1:0] status;
    logic [NUM_ALARMS-1:0] irq_en;
    logic [NUM_ALARMS-1:0] armed;
    logic [NUM_ALARMS-1:0] periodic;
    logic [15:0]           period [NUM_ALARMS];
    logic [15:0]           count  [NUM_ALARMS];

    logic                  wr_en, rd_en;
    logic [NUM_ALARMS-1:0] ctrl_wr, period_wr, expire, w1c;
    logic [15:0]           rd_mux;

    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        tick           = 1'b0;
        tmr_address    = 3'd0;
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_writedata  = 16'h0000;
        case (state)
            INIT: begin
                tmr_address    = 3'd1;
                tmr_writedata  = 16'h0007;
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                if (!tmr_waitrequest) state_nxt = IDLE;
            end
            IDLE: begin
                if (tmr_irq) begin
                    state_nxt = ACK;
                    tick      = 1'b1;
                end
            end
            ACK: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                if (!tmr_waitrequest) state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                // the timer's irq may still be high for a cycle after the ack lands
                if (!tmr_irq) state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
        if (reset) begin
            tick           = 1'b0;
            tmr_chipselect = 1'b0;
            tmr_write_n    = 1'b1;
            tmr_address    = 3'd0;
            tmr_writedata  = 16'h0000;
        end
    end

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;
    assign w1c   = (wr_en && address == 4'd2) ? writedata[NUM_ALARMS-1:0] : '0;

    always_comb begin
        ctrl_wr   = '0;
        period_wr = '0;
        expire    = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            period_wr[i] = wr_en && (address == 4'(4 + 2 * i));
            ctrl_wr[i]   = wr_en && (address == 4'(5 + 2 * i));
            // a CTRL write in the tick cycle takes precedence, so no expiry then
            expire[i]    = tick && armed[i] && !ctrl_wr[i] && (count[i] <= 16'd1);
        end
    end

    always_comb begin
        rd_mux = 16'h0000;
        case (address)
            4'd0: rd_mux = ts[15:0];
            4'd1: rd_mux = ts_shadow;
            4'd2: rd_mux[NUM_ALARMS-1:0] = status;
            4'd3: rd_mux[NUM_ALARMS-1:0] = irq_en;
            default: begin
                for (int i = 0; i < NUM_ALARMS; i++) begin
                    if (address == 4'(4 + 2 * i)) rd_mux = period[i];
                    if (address == 4'(5 + 2 * i)) rd_mux = {14'd0, periodic[i], armed[i]};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts        <= 32'd0;
            ts_shadow <= 16'd0;
            status    <= '0;
            irq_en    <= '0;
            armed     <= '0;
            periodic  <= '0;
            readdata  <= 16'd0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                period[i] <= 16'd0;
                count[i]  <= 16'd0;
            end
        end else begin
            if (tick) ts <= ts + 32'd1;
            if (rd_en) begin
                readdata <= rd_mux;
                if (address == 4'd0) ts_shadow <= ts[31:16];
            end
            if (wr_en && address == 4'd3) irq_en <= writedata[NUM_ALARMS-1:0];
            // set beats clear when an expiry and its W1C share a cycle
            status <= (status & ~w1c) | expire;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (period_wr[i]) period[i] <= writedata;
                if (ctrl_wr[i]) begin
                    periodic[i] <= writedata[1];
                    if (writedata[0] && period[i] != 16'd0) begin
                        armed[i] <= 1'b1;
                        count[i] <= period[i];
                    end else begin
                        armed[i] <= 1'b0;
                    end
                end else if (tick && armed[i]) begin
                    if (count[i] > 16'd1)                       count[i] <= count[i] - 16'd1;
                    else if (periodic[i] && period[i] != 16'd0) count[i] <= period[i];
                    else                                        armed[i] <= 1'b0;
                end
            end
        end
    end

    assign irq = |(status & irq_en);

endmodule

// File: tb/tb_limbus_usec_scheduler.sv
// Directed bench for limbus_usec_scheduler: hand-driven timer handshake and CPU register accesses.
module tb_limbus_usec_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        tmr_irq;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_waitrequest;
    logic [3:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    limbus_usec_scheduler #(.NUM_ALARMS(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .tmr_irq         (tmr_irq),
        .tmr_address     (tmr_address),
        .tmr_chipselect  (tmr_chipselect),
        .tmr_write_n     (tmr_write_n),
        .tmr_writedata   (tmr_writedata),
        .tmr_waitrequest (tmr_waitrequest),
        .address         (address),
        .chipselect      (chipselect),
        .read_n          (read_n),
        .write_n         (write_n),
        .writedata       (writedata),
        .readdata        (readdata),
        .irq             (irq)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ts   = 32'd0;
    logic [18:0] wr_q [$];

    // completed timer writes as {address, data}
    always @(posedge clk)
        if (tmr_chipselect && !tmr_write_n && !tmr_waitrequest)
            wr_q.push_back({tmr_address, tmr_writedata});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [15:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic cpu_rd(input logic [3:0] a, output logic [15:0] d);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        step();
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

    // irq high for 3 cycles; optional CPU write lands on the tick edge
    task automatic tick_wr(input logic we, input logic [3:0] a, input logic [15:0] d);
        tmr_irq = 1'b1;
        if (we) begin
            chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        end
        step();
        chipselect = 1'b0; write_n = 1'b1;
        step();
        step();
        tmr_irq = 1'b0;
        step();
        step();
        exp_ts = exp_ts + 32'd1;
    endtask

    task automatic tick();
        tick_wr(1'b0, 4'd0, 16'd0);
    endtask

    task automatic check_ts(input string tag);
        logic [15:0] lo, hi;
        cpu_rd(4'd0, lo);
        cpu_rd(4'd1, hi);
        check(tag, {hi, lo}, exp_ts);
    endtask

    task automatic check_status(input string tag, input logic [15:0] exp);
        logic [15:0] v;
        cpu_rd(4'd2, v);
        check(tag, v, exp);
    endtask

    initial begin
        logic [15:0] v, lo, hi;
        reset = 1'b1; tmr_irq = 1'b0; tmr_waitrequest = 1'b0;
        address = 4'd0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; writedata = 16'd0;
        repeat (3) step();

        // reset state
        check("rst_cs", tmr_chipselect, 0);
        check("rst_write_n", tmr_write_n, 1);
        check("rst_irq", irq, 0);
        check("rst_readdata", readdata, 0);

        reset = 1'b0;
        #1;
        check("init_cs", tmr_chipselect, 1);
        check("init_addr", tmr_address, 1);
        check("init_data", tmr_writedata, 16'h0007);
        step();
        step();
        check("init_count", wr_q.size(), 1);
        if (wr_q.size() > 0) check("init_write", wr_q.pop_front(), {3'd1, 16'h0007});
        check("bus_idle", tmr_chipselect, 0);

        // five ticks, five acks
        repeat (5) tick();
        check("ack_count", wr_q.size(), 5);
        while (wr_q.size() > 0) check("ack_write", wr_q.pop_front(), 19'h0);
        check_ts("ts_after_5");

        // ack held off by waitrequest for four edges
        tmr_irq = 1'b1; tmr_waitrequest = 1'b1;
        step();
        exp_ts = exp_ts + 32'd1;
        for (int k = 0; k < 4; k++) begin
            check("ack_hold_cs", tmr_chipselect, 1);
            step();
        end
        tmr_waitrequest = 1'b0;
        check("ack_hold_addr", tmr_address, 0);
        step();
        tmr_irq = 1'b0;
        check("ack_released", tmr_chipselect, 0);
        step();
        step();
        check("stall_ack_count", wr_q.size(), 1);
        wr_q.delete();
        check_ts("ts_after_stall");

        // one-shot alarm 0
        cpu_wr(4'd4, 16'd3);
        cpu_wr(4'd5, 16'h1);
        cpu_wr(4'd3, 16'h1);
        cpu_rd(4'd5, v);
        check("ctrl0_armed", v, 16'h1);
        tick();
        tick();
        check_status("oneshot_t2", 16'h0);
        tick();
        check_status("oneshot_t3", 16'h1);
        check("oneshot_irq", irq, 1);
        cpu_rd(4'd5, v);
        check("ctrl0_disarmed", v, 16'h0);
        cpu_wr(4'd2, 16'h1);
        check("w1c_irq", irq, 0);

        // register readback, arming with zero period, unmapped space
        cpu_rd(4'd3, v);
        check("irq_en_rb", v, 16'h1);
        cpu_wr(4'd9, 16'h1);
        cpu_rd(4'd9, v);
        check("arm_zero_period", v, 16'h0);
        cpu_wr(4'd12, 16'h0055);
        cpu_rd(4'd12, v);
        check("unmapped_12", v, 16'h0);
        cpu_rd(4'd15, v);
        check("unmapped_15", v, 16'h0);

        // periodic alarm 1, W1C colliding with the tick-4 expiry
        cpu_wr(4'd6, 16'd2);
        cpu_wr(4'd7, 16'h3);
        for (int t = 1; t <= 7; t++) begin
            if (t == 4) tick_wr(1'b1, 4'd2, 16'h2);
            else        tick();
            check_status($sformatf("periodic_t%0d", t), (t % 2 == 0) ? 16'h2 : 16'h0);
            if (t == 2) check("periodic_masked_irq", irq, 0);
            if (t % 2 == 0) cpu_wr(4'd2, 16'h2);
        end
        cpu_rd(4'd7, v);
        check("ctrl1_rb", v, 16'h3);
        // count is 1 now; zeroing PERIOD leaves it to expire once, then disarm
        cpu_wr(4'd6, 16'd0);
        tick();
        check_status("periodic_last", 16'h2);
        cpu_rd(4'd7, v);
        check("ctrl1_zero_reload", v, 16'h2);
        cpu_wr(4'd2, 16'h2);

        // arming on the tick edge: tick ignored, expiry three ticks later
        tick_wr(1'b1, 4'd5, 16'h1);
        tick();
        tick();
        check_status("ctrl_vs_tick_early", 16'h0);
        tick();
        check_status("ctrl_vs_tick_fire", 16'h1);
        cpu_wr(4'd2, 16'h1);

        // timestamp wrap and shadow coherency
        force dut.ts = 32'h0000_FFFE;
        step();
        release dut.ts;
        exp_ts = 32'h0000_FFFE;
        tick();
        check_ts("ts_ffff");
        tick();
        check_ts("ts_10000");
        force dut.ts = 32'h0001_FFFF;
        step();
        release dut.ts;
        cpu_rd(4'd0, lo);
        tick();
        cpu_rd(4'd1, hi);
        check("shadow_coherent", {hi, lo}, 32'h0001_FFFF);
        force dut.ts = 32'hFFFF_FFFF;
        step();
        release dut.ts;
        exp_ts = 32'hFFFF_FFFF;
        tick();
        check_ts("ts_wrap32");

        // reset in the middle of a stalled ack
        wr_q.delete();
        tmr_waitrequest = 1'b1; tmr_irq = 1'b1;
        step();
        check("mid_ack_cs", tmr_chipselect, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_cs", tmr_chipselect, 0);
        check("mid_rst_write_n", tmr_write_n, 1);
        step();
        step();
        tmr_irq = 1'b0; tmr_waitrequest = 1'b0; reset = 1'b0;
        #1;
        check("reinit_addr", tmr_address, 1);
        check("reinit_data", tmr_writedata, 16'h0007);
        step();
        step();
        check("reinit_count", wr_q.size(), 1);
        if (wr_q.size() > 0) check("reinit_write", wr_q.pop_front(), {3'd1, 16'h0007});
        exp_ts = 32'd0;
        check_ts("ts_after_reset");
        check_status("status_after_reset", 16'h0);
        check("irq_after_reset", irq, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
